// File: rtl/pipelined_adder_seg.sv
// rtl/pipelined_adder_seg.sv - segmented carry-ripple pipelined adder, one register stage per segment
// Optional output backpressure (in_ready/out_ready) enabled by PIPE_ADD_STALL_EN.
module pipelined_adder_seg #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] n1,
   input  logic [WIDTH-1:0] n2,
   input  logic             cin,
   input  logic             signed_mode,
`ifdef PIPE_ADD_STALL_EN
   input  logic             out_ready,
   output logic             in_ready,
`endif
   output logic             out_valid,
   output logic [WIDTH:0]   sum,
   output logic             overflow
);

   localparam int SEG = WIDTH / STAGES;
   localparam int NR  = (STAGES > 1) ? STAGES - 1 : 1;

   // Inter-stage registers: element k feeds stage k+1. Operands are stored
   // pre-shifted so the next segment to consume always sits in the low bits.
   logic [WIDTH-1:0] a_d [NR];
   logic [WIDTH-1:0] a_q [NR];
   logic [WIDTH-1:0] b_d [NR];
   logic [WIDTH-1:0] b_q [NR];
   logic [WIDTH-1:0] ps_d [NR];
   logic [WIDTH-1:0] ps_q [NR];
   logic             c_d [NR];
   logic             c_q [NR];
   logic             sm_d [NR];
   logic             sm_q [NR];
   logic             v_d [NR];
   logic             v_q [NR];

   logic [WIDTH:0]   sum_d, sum_q;
   logic             ovf_d, ovf_q;
   logic             out_valid_d, out_valid_q;
   logic             adv;

   // Extension bit is the operand sign only in the top segment of a signed add.
   function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                            input logic [SEG-1:0] b,
                                            input logic           c,
                                            input logic           ext);
      logic ea, eb;
      ea = ext & a[SEG-1];
      eb = ext & b[SEG-1];
      return {ea, a} + {eb, b} + {{SEG{1'b0}}, c};
   endfunction

`ifdef PIPE_ADD_STALL_EN
   always_comb begin
      adv      = ~(out_valid_q & ~out_ready);
      in_ready = rst | adv;
   end
`else
   always_comb begin
      adv = 1'b1;
   end
`endif

   always_comb begin
      logic [WIDTH-1:0] ca, cb, cps, nps;
      logic             cc, csm, cv;
      logic [SEG:0]     r;
      for (int i = 0; i < NR; i++) begin
         a_d[i]  = '0;
         b_d[i]  = '0;
         ps_d[i] = '0;
         c_d[i]  = 1'b0;
         sm_d[i] = 1'b0;
         v_d[i]  = 1'b0;
      end
      sum_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      ca  = n1;
      cb  = n2;
      cc  = cin;
      csm = signed_mode;
      cv  = in_valid;
      cps = '0;
      r   = '0;
      nps = '0;
      for (int k = 0; k < STAGES; k++) begin
         r   = seg_add(ca[SEG-1:0], cb[SEG-1:0], cc, csm & (k == STAGES - 1));
         nps = cps | (WIDTH'(r[SEG-1:0]) << (k * SEG));
         if (k == STAGES - 1) begin
            sum_d       = {r[SEG], nps};
            ovf_d       = csm ? (r[SEG] ^ nps[WIDTH-1]) : r[SEG];
            out_valid_d = cv;
         end else begin
            a_d[k]  = ca >> SEG;
            b_d[k]  = cb >> SEG;
            c_d[k]  = r[SEG];
            ps_d[k] = nps;
            sm_d[k] = csm;
            v_d[k]  = cv;
            ca  = a_q[k];
            cb  = b_q[k];
            cc  = c_q[k];
            csm = sm_q[k];
            cv  = v_q[k];
            cps = ps_q[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NR; i++) begin
            a_q[i]  <= '0;
            b_q[i]  <= '0;
            ps_q[i] <= '0;
            c_q[i]  <= 1'b0;
            sm_q[i] <= 1'b0;
            v_q[i]  <= 1'b0;
         end
         sum_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (adv) begin
         for (int i = 0; i < NR; i++) begin
            a_q[i]  <= a_d[i];
            b_q[i]  <= b_d[i];
            ps_q[i] <= ps_d[i];
            c_q[i]  <= c_d[i];
            sm_q[i] <= sm_d[i];
            v_q[i]  <= v_d[i];
         end
         out_valid_q <= out_valid_d;
         // Result registers keep the last value across bubbles.
         if (out_valid_d) begin
            sum_q <= sum_d;
            ovf_q <= ovf_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_seg.sv
// tb/tb_pipelined_adder_seg.sv - self-checking bench for pipelined_adder_seg (WIDTH=16, STAGES=2)
// Stall scenario is compiled only with PIPE_ADD_STALL_EN.
module tb_pipelined_adder_seg;

   localparam int W = 16;
   localparam int S = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [W-1:0]  n1 = '0;
   logic [W-1:0]  n2 = '0;
   logic          cin = 1'b0;
   logic          signed_mode = 1'b0;
   logic          out_ready = 1'b1;
   logic          out_valid;
   logic [W:0]    sum;
   logic          overflow;
`ifdef PIPE_ADD_STALL_EN
   logic          in_ready;
`endif

   int checks = 0;
   int errors = 0;

   pipelined_adder_seg #(.WIDTH(W), .STAGES(S)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .n1          (n1),
      .n2          (n2),
      .cin         (cin),
      .signed_mode (signed_mode),
`ifdef PIPE_ADD_STALL_EN
      .out_ready   (out_ready),
      .in_ready    (in_ready),
`endif
      .out_valid   (out_valid),
      .sum         (sum),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference result as {overflow, sum[16:0]} from plain integer arithmetic.
   function automatic logic [17:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic sm);
      int  r;
      logic ov;
      if (sm) begin
         r  = int'($signed(a)) + int'($signed(b)) + int'(c);
         ov = (r > 32767) || (r < -32768);
      end else begin
         r  = int'(a) + int'(b) + int'(c);
         ov = (r > 65535);
      end
      return {ov, r[16:0]};
   endfunction

   // Model: a delay line of S optional results, advancing unless the output is stalled.
   logic          mv [S];
   logic [17:0]   mr [S];
   logic [W:0]    m_sum = '0;
   logic          m_ovf = 1'b0;
   logic          live = 1'b0;

   always @(posedge clk) begin : model
      logic stall_m;
      if (rst) begin
         for (int i = 0; i < S; i++) begin
            mv[i] = 1'b0;
            mr[i] = '0;
         end
         m_sum = '0;
         m_ovf = 1'b0;
         live  = 1'b1;
      end else begin
         stall_m = mv[S-1] && !out_ready;
         if (!stall_m) begin
            for (int i = S - 1; i > 0; i--) begin
               mv[i] = mv[i-1];
               mr[i] = mr[i-1];
            end
            mv[0] = in_valid;
            mr[0] = ref_add(n1, n2, cin, signed_mode);
            if (mv[S-1]) {m_ovf, m_sum} = mr[S-1];
         end
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("out_valid", out_valid, mv[S-1]);
         chk("sum", sum, m_sum);
         chk("overflow", overflow, m_ovf);
`ifdef PIPE_ADD_STALL_EN
         chk("in_ready", in_ready, rst || !(mv[S-1] && !out_ready));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic sm, input logic [W:0] es, input logic eo);
      in_valid = 1'b1; n1 = a; n2 = b; cin = c; signed_mode = sm;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk({name, "_early"}, out_valid, 0);
      step();
      @(negedge clk);
      chk({name, "_valid"}, out_valid, 1);
      chk({name, "_sum"}, sum, es);
      chk({name, "_ovf"}, overflow, eo);
      step();
   endtask

   initial begin
      chk("pin_signed_pos", ref_add(16'h7FFF, 16'h0001, 1'b0, 1'b1), 18'h28000);
      chk("pin_signed_neg", ref_add(16'hFFFF, 16'hFFFF, 1'b0, 1'b1), 18'h1FFFE);
      chk("pin_unsigned", ref_add(16'hFFFF, 16'h0000, 1'b1, 1'b0), 18'h30000);

      @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_sum", sum, 0);
      chk("reset_ovf", overflow, 0);
      step();
      rst = 1'b0;

      directed("carry_seg", 16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h00100, 1'b0);
      directed("uns_ovf",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000, 1'b1);
      directed("sgn_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b1, 17'h08000, 1'b1);
      directed("sgn_m1m1",  16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 17'h1FFFE, 1'b0);
      directed("sgn_min",   16'h8000, 16'h8000, 1'b0, 1'b1, 17'h10000, 1'b1);
      directed("uns_zero",  16'h0000, 16'h0000, 1'b0, 1'b0, 17'h00000, 1'b0);

      for (int i = 0; i < 100; i++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         n1          = W'($urandom);
         n2          = W'($urandom);
         cin         = 1'($urandom);
         signed_mode = 1'($urandom);
         step();
      end
      in_valid = 1'b0;
      repeat (4) step();

      // Reset while results are in flight: nothing issued before it may emerge.
      in_valid = 1'b1; n1 = 16'h1234; n2 = 16'h1111; cin = 1'b0; signed_mode = 1'b0;
      step();
      n1 = 16'h4321; n2 = 16'h2222;
      step();
      rst = 1'b1; n1 = 16'h5555; n2 = 16'h3333;
      step();
      @(negedge clk);
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_sum", sum, 0);
      chk("rst_mid_ovf", overflow, 0);
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      repeat (5) step();

`ifdef PIPE_ADD_STALL_EN
      for (int i = 0; i < 16; i++) begin
         in_valid    = 1'b1;
         n1          = W'($urandom);
         n2          = W'($urandom);
         cin         = 1'($urandom);
         signed_mode = 1'($urandom);
         out_ready   = !(i >= 4 && i < 9);
         if (i == 6) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
         end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (6) step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_adder_seg.md
# pipelined_adder_seg

Parametrised, valid-tagged pipelined adder that splits a WIDTH-bit addition into STAGES equal segments and ripples the carry through one register stage per segment. It adds per-transaction signed/unsigned mode, carry-in and an overflow flag, and can optionally accept output backpressure. It is the general-purpose replacement for the fixed 16-bit two-stage adder in the datapath library. Every stage sustains one result per cycle.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of STAGES.
- STAGES, 2, number of pipeline segments (1..WIDTH); segment width SEG = WIDTH/STAGES.

- clk  input  1  rising-edge clock; only clock in the block.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  n1/n2/cin/signed_mode are valid this cycle.
- n1  input  WIDTH  operand A.
- n2  input  WIDTH  operand B.
- cin  input  1  carry-in, added at bit 0.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  output  1  sum/overflow hold a result.
- sum  output  WIDTH+1  exact result: n1 + n2 + cin, extended by one bit.
- overflow  output  1  the WIDTH-bit truncated result is not exact.
- in_ready  output  1  only present with PIPE_ADD_STALL_EN.
- out_ready  input  1  only present with PIPE_ADD_STALL_EN.

## Operation
- Segment k covers bits [(k+1)*SEG-1 : k*SEG], where k = 0..STAGES-1.
- Stage 0 adds segment 0 of n1 and n2 plus cin, then registers the SEG-bit partial sum and the carry.
- Stage k (k ≥ 1) adds segment k of the skew-delayed operands plus the registered carry from stage k-1.
- Operand segments not yet consumed are carried forward in skew registers, together with signed_mode and the valid bit.
- Partial sums of lower segments are carried forward unchanged.
- Top segment, signed_mode=1: both operands are sign-extended by 1 bit; sum[WIDTH] is the sign of the true result.
- Top segment, signed_mode=0: both operands are zero-extended; sum[WIDTH] is the carry-out.
- overflow, unsigned: overflow = sum[WIDTH].
- overflow, signed: overflow = (sum[WIDTH] != sum[WIDTH-1]).
- cin is always treated as +1 and is never sign-extended.
- Results appear in input order. Invalid cycles produce bubbles. sum/overflow hold their last value while out_valid=0.
- STAGES=1: a single registered full-width add.

## Timing
- Latency: an input sampled at edge t appears with out_valid=1 after edge t+STAGES−1, i.e. it is visible in the cycle following edge t+STAGES−1 (STAGES=2: two cycles, the same as the legacy adder).
- Throughput: 1 result per cycle with no stalls.
- Reset: all pipeline valid bits, skew registers, sum, overflow and out_valid are cleared to 0 on the first edge with rst=1.
- Reset mid-operation: in-flight results are discarded and never emitted. in_valid is ignored while rst=1.
- First accepted input after rst falls: it is sampled on the first edge with rst=0.

## Configuration
- PIPE_ADD_STALL_EN defined:
  - Adds in_ready and out_ready.
  - stall = out_valid & ~out_ready. While stalled, every pipeline register, including the output, holds.
  - in_ready = ~stall. An input is accepted only when in_valid & in_ready.
  - No results are lost or duplicated.
  - in_ready is combinational from out_ready.
  - During reset, in_ready = 1.
- PIPE_ADD_STALL_EN undefined:
  - The ports are absent and the pipeline free-runs.
  - A downstream consumer must accept every result.

## Test plan
All scenarios use WIDTH=16, STAGES=2.
- Cross-segment carry:
  - Stimulus: unsigned 0x00FF + 0x0001, cin=0.
  - Response: sum=17'h00100 and overflow=0, exactly 2 cycles after input.
- Unsigned overflow:
  - Stimulus: 0xFFFF + 0x0000, cin=1.
  - Response: sum=17'h10000, overflow=1.
- Signed results:
  - Stimulus 1: 0x7FFF + 0x0001. Response: sum=17'h08000, overflow=1.
  - Stimulus 2: 0xFFFF + 0xFFFF. Response: sum=17'h1FFFE, overflow=0.
  - Stimulus 3: 0x8000 + 0x8000. Response: sum=17'h10000, overflow=1.
- Streaming:
  - Stimulus: 100 random back-to-back inputs with mixed signed_mode and random bubbles.
  - Response: out_valid pattern equals the in_valid pattern delayed by 2 cycles, and every result matches the reference model.
- Reset mid-flight:
  - Stimulus: assert rst for 1 cycle while 2 results are in flight.
  - Response: out_valid=0, sum=0 and overflow=0 on the next cycle, and no stale result ever appears.
- Stall (PIPE_ADD_STALL_EN):
  - Stimulus: hold out_ready=0 for 5 cycles during continuous input.
  - Response: in_ready=0 while stalled, sum is held stable, and the sequence after release is complete and in order.
